// File: rtl/mux4_rr_arbiter.sv
// ============================================================================
// Module   : mux4_rr_arbiter
// Purpose  : Round-robin scheduler driving the registered select of a 4:1 data
//            mux, with a valid/ready output port and a wrapping transfer count.
//            Define MUX4_ARB_PRIO_EN to give requester 0 fixed high priority.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mux4_rr_arbiter #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    output logic [3:0]        gnt,
    output logic [1:0]        sel,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  xfer_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         gnt_q, gnt_d;
    logic [1:0]         sel_q, sel_d;
    logic [1:0]         last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               ack;
    logic               arb_en;
    logic [3:0]         arb_req;
    logic [2:0]         rr_res;
    logic               win_found;
    logic [1:0]         win_idx;
    logic               win_is_rr;

    // Returns {found, index} of the first set bit after 'last', wrapping mod 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        ack     = (state_q == ST_GRANT) && out_ready;
        arb_en  = (state_q == ST_IDLE) || ack;
        arb_req = (state_q == ST_GRANT) ? (req & ~gnt_q) : req;
        rr_res  = rr_pick(arb_req, last_q);
`ifdef MUX4_ARB_PRIO_EN
        if (arb_req[0]) begin
            win_found = 1'b1;
            win_idx   = 2'd0;
            win_is_rr = 1'b0;
        end else begin
            win_found = rr_res[2];
            win_idx   = rr_res[1:0];
            win_is_rr = 1'b1;
        end
`else
        win_found = rr_res[2];
        win_idx   = rr_res[1:0];
        win_is_rr = 1'b1;
`endif
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (ack) cnt_d = cnt_q + 1'b1;
        if (arb_en) begin
            if (win_found) begin
                state_d = ST_GRANT;
                gnt_d   = 4'b0001 << win_idx;
                sel_d   = win_idx;
                if (win_is_rr) last_d = win_idx;
            end else begin
                // sel deliberately keeps its value so it is stable while idle
                state_d = ST_IDLE;
                gnt_d   = 4'b0000;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        case (sel_q)
            2'd0:    out_data = in0;
            2'd1:    out_data = in1;
            2'd2:    out_data = in2;
            default: out_data = in3;
        endcase
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign out_valid = (state_q == ST_GRANT);
    assign xfer_cnt  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
// ============================================================================
// Module   : tb_mux4_rr_arbiter
// Purpose  : Scoreboard bench for mux4_rr_arbiter: a behavioural model queues
//            the expected outputs each cycle, a monitor compares them.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mux4_rr_arbiter;

    localparam int DW = 8;
    localparam int CW = 10;
    localparam time C_TIMEOUT = 1000000;

    logic          clk;
    logic          rst_n;
    logic [3:0]    req;
    logic [DW-1:0] din [4];
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] xfer_cnt;

    mux4_rr_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in0       (din[0]),
        .in1       (din[1]),
        .in2       (din[2]),
        .in3       (din[3]),
        .gnt       (gnt),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xfer_cnt  (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    gnt;
        logic [1:0]    sel;
        logic          valid;
        logic [DW-1:0] data;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    event chk_now;
    int   vectors;
    int   miscompares;
    bit   done;

    bit            m_valid;
    int            m_sel;
    int            m_last;
    logic [CW-1:0] m_cnt;

    function automatic void model_reset();
        m_valid = 0;
        m_sel   = 0;
        m_last  = 3;
        m_cnt   = '0;
    endfunction

    function automatic void model_arbitrate(input logic [3:0] avail);
        int winner;
        winner = -1;
`ifdef MUX4_ARB_PRIO_EN
        if (avail[0]) winner = 0;
`endif
        if (winner < 0) begin
            for (int k = 1; k <= 4; k++) begin
                if (winner < 0 && avail[(m_last + k) % 4]) winner = (m_last + k) % 4;
            end
            if (winner >= 0) m_last = winner;
        end
        if (winner >= 0) begin
            m_valid = 1;
            m_sel   = winner;
        end else begin
            m_valid = 0;
        end
    endfunction

    function automatic void model_clock(input logic [3:0] r, input logic rdy);
        logic [3:0] avail;
        if (m_valid) begin
            if (rdy) begin
                m_cnt = m_cnt + 1'b1;
                avail = r;
                avail[m_sel] = 1'b0;
                model_arbitrate(avail);
            end
        end else begin
            model_arbitrate(r);
        end
    endfunction

    function automatic void push_expected();
        exp_t e;
        e.valid = m_valid;
        e.gnt   = m_valid ? 4'(1 << m_sel) : 4'b0000;
        e.sel   = 2'(m_sel);
        e.data  = din[m_sel];
        e.cnt   = m_cnt;
        exp_q.push_back(e);
    endfunction

    initial begin
        exp_t e;
        vectors = 0;
        miscompares = 0;
        forever begin
            @(negedge clk or chk_now);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (gnt !== e.gnt || sel !== e.sel || out_valid !== e.valid ||
                    out_data !== e.data || xfer_cnt !== e.cnt) begin
                    miscompares++;
                    $display("FAIL outputs @%0t: got gnt=%b sel=%0d valid=%b data=%h cnt=%0d, expected gnt=%b sel=%0d valid=%b data=%h cnt=%0d",
                             $time, gnt, sel, out_valid, out_data, xfer_cnt,
                             e.gnt, e.sel, e.valid, e.data, e.cnt);
                end
            end
        end
    end

    initial begin
        done = 1'b0;
        #(C_TIMEOUT);
        if (!done) begin
            miscompares++;
            $display("FAIL timeout @%0t: stimulus did not complete within %0t", $time, C_TIMEOUT);
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $display("TEST FAILED");
            $finish;
        end
    end

    task automatic check_reset_state();
        if (gnt !== 4'b0000 || sel !== 2'd0 || out_valid !== 1'b0 || xfer_cnt !== '0) begin
            miscompares++;
            $display("FAIL reset state @%0t: gnt=%b sel=%0d valid=%b cnt=%0d, expected all zero",
                     $time, gnt, sel, out_valid, xfer_cnt);
        end
    endtask

    task automatic step(input logic [3:0] nreq, input logic nrdy);
        logic [3:0] r;
        logic       rd;
        r  = req;
        rd = out_ready;
        @(posedge clk);
        #1;
        model_clock(r, rd);
        req       = nreq;
        out_ready = nrdy;
        for (int i = 0; i < 4; i++) begin
            if (!(m_valid && m_sel == i)) din[i] = DW'($urandom);
        end
        push_expected();
    endtask

    task automatic apply_reset(input int hold);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_state();
        model_reset();
        push_expected();
        -> chk_now;
        repeat (hold) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b1;
        req       = 4'b0000;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) din[i] = DW'($urandom);
        model_reset();
        apply_reset(2);

        for (int i = 0; i < 8; i++) step(4'b0100, 1'b1);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);

        for (int i = 0; i < 10; i++) step(4'b1111, 1'b1);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);

        for (int i = 0; i < 6; i++) step(4'b0011, 1'b0);
        for (int i = 0; i < 4; i++) step(4'b0011, 1'b1);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);

        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b0);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b0);

        for (int i = 0; i < 8; i++) step(4'b1110, 1'b1);
        for (int i = 0; i < 8; i++) step(4'b1011, 1'b1);

        step(4'b1000, 1'b0);
        step(4'b1000, 1'b0);
        apply_reset(3);
        step(4'b0001, 1'b1);
        step(4'b0001, 1'b1);

        for (int i = 0; i < 1100; i++) step(4'b1111, 1'b1);

        for (int i = 0; i < 3000; i++) step(4'($urandom), ($urandom_range(0, 3) != 0));

        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        if (miscompares == 0) $display("TEST PASSED");
        else                  $display("TEST FAILED");
        $finish;
    end

endmodule

`default_nettype wire
